serial_bit_source: RTL

//   Parallel-to-serial stage upstream of the non-overlapping Mealy sequence detector.

---
 rtl/serial_bit_source.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial stage feeding the sequence detector.
// Takes WIDTH-bit words on a valid/ready handshake and emits one bit per clk.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_data      word to serialize
//   in_valid     in_data is valid
//   in_ready     block can take a word this cycle (decoded from state/counters)
//   out          serial bit, 0 whenever out_valid is low
//   out_valid    out carries a word bit this cycle
//   frame_start  high with the first bit of each word
//   busy         state != IDLE
module serial_bit_source #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = 8;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = (GAP == 0) ? GAP_W'(0) : GAP_W'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0]   shreg_shifted;
  logic               next_bit;

  // Shift away the bit just sent, towards the output end.
  always_comb begin
    if (MSB_FIRST) shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    else           shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
  end

  // State register and datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Next-state, counters and handshake decode.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    in_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = in_data;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          if (GAP == 0) begin
            // Seamless reload: next word starts right after this last bit.
            in_ready = 1'b1;
            if (in_valid) begin
              shreg_d   = in_data;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end else begin
          shreg_d   = shreg_shifted;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_d   = ST_SHIFT;
            shreg_d   = in_data;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit currently at the output end of the next shift register value.
  assign next_bit = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];

  // Outputs registered from next-state values so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out         <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      out         <= (state_d == ST_SHIFT) ? next_bit : 1'b0;
      out_valid   <= (state_d == ST_SHIFT);
      frame_start <= (state_d == ST_SHIFT) && (bit_cnt_d == '0);
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule
